// File: rtl/rv_multicycle_core.sv
`default_nettype none
// ============================================================================
// rv_multicycle_core : multicycle RV32I-subset core with one shared memory port
// Optional RV_BRANCH_EXT_EN adds bne/blt/bge/bltu/bgeu.    Revision: 1.0
// ============================================================================
module rv_multicycle_core #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc_out,
  output logic [31:0] alu_result,
  output logic        halted
);
  localparam int RW = (REG_COUNT == 16) ? 4 : 5;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [3:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, old_pc_q, old_pc_d, ir_q, ir_d;
  logic [31:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d, data_q, data_d;

  logic [31:0] rf [REG_COUNT];
  logic        rf_we;
  logic [31:0] rf_wdata;

  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3;
  logic [RW-1:0] rs1, rs2, rd;
  logic [31:0]   imm_i, imm_s, imm_b, imm_j, rs1_val, rs2_val;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];
  assign rd     = ir_q[7 +: RW];
  assign rs1    = ir_q[15 +: RW];
  assign rs2    = ir_q[20 +: RW];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign rs1_val = (rs1 == '0) ? 32'h0 : rf[rs1];
  assign rs2_val = (rs2 == '0) ? 32'h0 : rf[rs2];

  // Single ALU shared by the register-register and register-immediate paths
  logic [31:0] alu_b, alu_y;
  logic        alu_sub;
  assign alu_b   = (state_q == S_EXECR) ? b_q : imm_i;
  assign alu_sub = (state_q == S_EXECR) && funct7[5];

  always_comb begin
    alu_y = 32'h0;
    case (funct3)
      3'b000:  alu_y = alu_sub ? (a_q - alu_b) : (a_q + alu_b);
      3'b010:  alu_y = {31'b0, $signed(a_q) < $signed(alu_b)};
      3'b110:  alu_y = a_q | alu_b;
      3'b111:  alu_y = a_q & alu_b;
      default: alu_y = 32'h0;
    endcase
  end

  logic i_legal, r_legal, br_legal, br_taken;
  assign i_legal = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                   (funct3 == 3'b110) || (funct3 == 3'b111);
  assign r_legal = ((funct7 == 7'h00) && i_legal) ||
                   ((funct7 == 7'h20) && (funct3 == 3'b000));

`ifdef RV_BRANCH_EXT_EN
  assign br_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (a_q == b_q);
      3'b001:  br_taken = (a_q != b_q);
      3'b100:  br_taken = ($signed(a_q) <  $signed(b_q));
      3'b101:  br_taken = ($signed(a_q) >= $signed(b_q));
      3'b110:  br_taken = (a_q <  b_q);
      3'b111:  br_taken = (a_q >= b_q);
      default: br_taken = 1'b0;
    endcase
  end
`else
  assign br_legal = (funct3 == 3'b000);
  assign br_taken = (a_q == b_q);
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    old_pc_d  = old_pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    data_d    = data_q;
    rf_we     = 1'b0;
    rf_wdata  = alu_out_q;
    case (state_q)
      S_FETCH: if (mem_ready) begin
        ir_d     = mem_rdata;
        old_pc_d = pc_q;
        pc_d     = pc_q + 32'd4;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        a_d       = rs1_val;
        b_d       = rs2_val;
        alu_out_d = old_pc_q + ((opcode == OP_JAL) ? imm_j : imm_b);
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_REG:            state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_BRANCH:         state_d = br_legal ? S_BEQ : S_HALT;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_out_d = a_q + ((opcode == OP_STORE) ? imm_s : imm_i);
        state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: if (mem_ready) begin
        data_d  = mem_rdata;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = data_q;
        state_d  = S_FETCH;
      end
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI: begin
        if ((state_q == S_EXECR) ? r_legal : i_legal) begin
          alu_out_d = alu_y;
          state_d   = S_ALUWB;
        end else begin
          state_d = S_HALT;
        end
      end
      S_ALUWB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        if (br_taken) pc_d = alu_out_q;
        state_d = S_FETCH;
      end
      S_JAL: begin
        pc_d      = alu_out_q;
        alu_out_d = old_pc_q + 32'd4;
        state_d   = S_ALUWB;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      old_pc_q  <= 32'h0;
      ir_q      <= 32'h0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      alu_out_q <= 32'h0;
      data_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      old_pc_q  <= old_pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      data_q    <= data_d;
    end
  end

  // Register file is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (rf_we && (rd != '0)) rf[rd] <= rf_wdata;
  end

  assign mem_req    = !reset && ((state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                                 (state_q == S_MEMWRITE));
  assign mem_we     = (state_q == S_MEMWRITE);
  assign mem_addr   = (state_q == S_FETCH) ? pc_q : alu_out_q;
  assign mem_wdata  = b_q;
  assign pc_out     = pc_q;
  assign alu_result = alu_out_q;
  assign halted     = (state_q == S_HALT);
endmodule
`default_nettype wire

// File: doc/rv_multicycle_core.md
# rv_multicycle_core

Multicycle RV32I-subset processor core with a single shared instruction/data memory port and a ready-based wait-state handshake. It replaces the single-cycle datapath: one ALU, one memory port, and a control FSM that sequences every instruction over 3–5 cycles plus memory wait states. It sits between the top-level testbench/SoC wrapper and an external unified memory.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- REG_COUNT, 32, architectural registers; 32 (RV32I) or 16 (RV32E; rs/rd index bit 4 ignored).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  32  byte address; valid while mem_req.
- mem_wdata  out  32  store data; valid while mem_req && mem_we.
- mem_rdata  in  32  read data; sampled on the edge where mem_ready = 1.
- mem_ready  in  1  completes the current transaction at this edge.
- pc_out  out  32  current PC register.
- alu_result  out  32  ALUOut register.
- halted  out  1  core stopped on an illegal instruction.

## Operation
- Instructions: lw, sw; R-type add, sub, slt, or, and; I-type addi, slti, ori, andi; beq; jal. x0 reads 0; writes to x0 are discarded.
- Architectural registers: PC, OldPC, IR, A, B, ALUOut, Data, register file.
- FSM states and actions (one cycle each unless waiting on memory):
  - FETCH: mem_req=1, mem_addr=PC, mem_we=0. On mem_ready: IR<=mem_rdata, OldPC<=PC, PC<=PC+4 → DECODE. Otherwise stay.
  - DECODE: A<=rf[rs1], B<=rf[rs2], ALUOut<=OldPC+imm (B-type or J-type per opcode). lw/sw→MEMADR, R→EXECUTER, I-ALU→EXECUTEI, beq→BEQ, jal→JAL, anything else→HALT.
  - MEMADR: ALUOut<=A+immI (lw) or A+immS (sw) → MEMREAD / MEMWRITE.
  - MEMREAD: mem_req=1, mem_addr=ALUOut. On mem_ready: Data<=mem_rdata → MEMWB.
  - MEMWB: rf[rd]<=Data → FETCH.
  - MEMWRITE: mem_req=1, mem_we=1, mem_addr=ALUOut, mem_wdata=B. On mem_ready → FETCH.
  - EXECUTER / EXECUTEI: ALUOut<=A op B / A op immI → ALUWB. Unsupported funct3/funct7 → HALT.
  - ALUWB: rf[rd]<=ALUOut → FETCH.
  - BEQ: if A==B, PC<=ALUOut → FETCH.
  - JAL: PC<=ALUOut, ALUOut<=OldPC+4 → ALUWB.
  - HALT: terminal; halted=1, mem_req=0; left only by reset.
- Arithmetic: 32-bit wrap-around add/sub; slt/slti signed compare; immediates sign-extended from bit 31 of IR.
- Word accesses only; mem_addr[1:0] passed through unchecked.

## Timing
- Reset: state=FETCH, PC=RESET_PC, IR/A/B/ALUOut/Data/OldPC=0, halted=0; mem_req forced 0 while reset is high. The register file is not reset.
- mem_req rises combinationally in the first cycle after reset deasserts.
- Handshake: mem_addr, mem_we and mem_wdata hold stable while mem_req=1 until an edge with mem_ready=1. mem_ready while mem_req=0 is ignored.
- Zero-wait cycle counts: lw 5, sw 4, R/I 4, beq 3, jal 4. Each wait cycle adds 1.
- Reset mid-transaction aborts immediately; no completion is owed to memory.
- Branch or jal target equal to its own address loops legally. It is not treated as halt.

## Configuration
- RV_BRANCH_EXT_EN defined: DECODE also accepts bne, blt, bge, bltu, bgeu. These use the BEQ state with the condition selected by funct3, signed or unsigned compare as specified, and take 3 cycles.
- RV_BRANCH_EXT_EN undefined: only funct3=000 branches are legal; any other branch funct3 → HALT.

## Test plan
- Reset with RESET_PC=32'h100, mem_ready=1 → first mem_addr=32'h100, pc_out=32'h104 after FETCH.
- addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sw x3,0x40(x0) → memory write addr 32'h40, wdata 32'h2. Total 16 cycles at zero wait.
- lw x4,0x40(x0) with mem_ready low for 3 cycles in MEMREAD → x4=2. Address and we stay stable throughout, and the instruction takes 8 cycles.
- beq x1,x1,-8 then jal x5,+16 → PC returns 8 bytes back. jal writes x5=OldPC+4 and PC=OldPC+16.
- Opcode 7'b0000000 → halted=1 after DECODE, mem_req stays 0; reset clears halted and refetches RESET_PC.
- bne x1,x2,+8 with x1≠x2: taken with RV_BRANCH_EXT_EN defined, halted=1 without it.
